bus_grant_arbiter: RTL and testbench
====================================

# bus_grant_arbiter

Upstream control stage for the shared 32-bit datapath bus. It arbitrates between the 25 register-out requests and the constant-source request, and drives the registered 5-bit `select` code that the bus multiplexer consumes. Code 1..25 selects source 0..24, code 31 selects the constant source, and code 0 means "no driver" (the multiplexer holds its last value). Ownership lasts until the owner releases or is pre-empted by a hold timeout. A one-cycle turnaround separates owners. The block also counts contention cycles.

## Interface
Parameters:
- `MAX_HOLD`, default 4: cycles an owner may keep the bus while another request is pending (valid range 1..15).
- `CONF_W`, default 8: width of the saturating contention counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `clear_n`  in  1  reset, synchronous, active-low. Sampled on the `clk` rising edge.
- `req`  in  25  per-source bus-out request; bit i corresponds to select code i+1.
- `const_req`  in  1  request to drive the constant source (select code 31).
- `conflict_clr`  in  1  synchronous clear of `conflict_cnt`.
- `select`  out  5  registered bus select code: 0 idle, 1..25 sources, 31 constant.
- `grant`  out  25  registered one-hot grant to the owning source. All zero when idle or when the constant owns the bus.
- `busy`  out  1  registered; 1 while any owner holds the bus.
- `conflict_cnt`  out  CONF_W  saturating count of contention cycles.

## Operation
- States: IDLE, OWN.
- Reset (`clear_n`=0 at an edge): state IDLE, `select`=0, `grant`=0, `busy`=0, `conflict_cnt`=0, `hold_cnt`=0, `last_owner`=24. A reset asserted mid-ownership takes effect at that edge and overrides every other input.
- IDLE, no request: outputs stay 0.
- IDLE, any request: pick a winner and move to OWN.
  - `const_req` has absolute priority and gives code 31 with `grant`=0.
  - Otherwise round-robin: scan from `last_owner`+1 upward, wrapping 24→0. The first set `req` bit i wins, giving code i+1 and `grant` bit i. Set `last_owner`=i.
  - `last_owner` is not updated when the constant wins.
- OWN: `select`, `grant` and `busy`=1 are held. `hold_cnt` increments each cycle and saturates at 15. "Other pending" means any `req` bit other than the owner's, or `const_req` when the owner is a source.
- Release from OWN to IDLE (`select`=0, `grant`=0, `busy`=0, `hold_cnt`=0) occurs when either:
  - the owner's request (`req[i]`, or `const_req` for the constant) is sampled low, or
  - `hold_cnt` = `MAX_HOLD`-1 and another request is pending.
- With no other request pending, the owner holds indefinitely; the timeout never fires.
- Requests are not latched. A request that drops before it is granted is lost.
- A released owner may win again from IDLE if it is still requesting. For sources, round-robin order still applies.
- `conflict_cnt` increments by 1 on each IDLE cycle where at least 2 requests (the `req` bits plus `const_req`) are asserted. It saturates at 2^CONF_W-1.
- `conflict_clr` sets `conflict_cnt` to 0 and wins over a same-cycle increment.

## Timing
- Grant latency: a request sampled in IDLE at edge n gives a valid `select`/`grant`/`busy` after edge n (visible during cycle n+1).
- Release: owner's request sampled low at edge m gives `select`=0 after edge m. The earliest next grant follows edge m+1, so there is always at least one idle turnaround cycle.
- Timeout: an owner granted at edge n that still holds with another request pending releases at edge n+`MAX_HOLD`. It drives exactly `MAX_HOLD` cycles.
- Simultaneous timeout and owner drop: a single release occurs, with identical behaviour.
- `select` changes only on clock edges and is glitch-free. It never takes values 26..30.
- `grant` is always one-hot or zero. `grant`≠0 implies `select`=index+1.

## Test plan
- Reset: drive `clear_n`=0 with all requests high → all outputs 0. Release reset with only `req[3]`=1 → next cycle `select`=4, `grant`=0x8, `busy`=1.
- Round-robin: hold `req[0]`, `req[5]` and `req[24]` high with `MAX_HOLD`=4 → the `select` sequence is 1,1,1,1,0,6,6,6,6,0,25,25,25,25,0,1. `conflict_cnt` increments by 1 on each 0 cycle.
- Constant priority: `req[7]` and `const_req` asserted together in IDLE → `select`=31, `grant`=0. Drop `const_req` → one cycle of `select`=0, then `select`=8.
- Unopposed hold: only `req[10]` high for 20 cycles → `select`=11 is held all 20 cycles with no timeout. `req[10]` goes low → `select`=0 next cycle.
- Counter: force contention for 300 cycles with `CONF_W`=8 → `conflict_cnt` saturates at 255. Assert `conflict_clr` during a contention cycle → 0.
- Reset mid-ownership: `clear_n`=0 while `select`=31 → outputs 0 next edge. After release of reset the round-robin restarts at source 0.

Source files
------------

// File: rtl/bus_grant_arbiter_if.sv
// Bus arbitration handshake bundle: requests in, select/grant/status out.
// The master side raises requests; the slave side is the arbiter.
interface bus_grant_arbiter_if #(
    parameter int CONF_W = 8
);
    logic [24:0]       req;
    logic              const_req;
    logic              conflict_clr;
    logic [4:0]        select;
    logic [24:0]       grant;
    logic              busy;
    logic [CONF_W-1:0] conflict_cnt;

    modport master (
        output req,
        output const_req,
        output conflict_clr,
        input  select,
        input  grant,
        input  busy,
        input  conflict_cnt
    );

    modport slave (
        input  req,
        input  const_req,
        input  conflict_clr,
        output select,
        output grant,
        output busy,
        output conflict_cnt
    );
endinterface

// File: rtl/bus_grant_arbiter.sv
// Shared-bus owner arbiter: constant source first, then round-robin over
// 25 sources, with hold timeout, idle turnaround and contention counter.
module bus_grant_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CONF_W   = 8
) (
    input  logic                 clk,
    input  logic                 clear_n,
    bus_grant_arbiter_if.slave   bus
);

    localparam logic       IDLE      = 1'b0;
    localparam logic       OWN       = 1'b1;
    localparam logic [4:0] CONST_SEL = 5'd31;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic              state_q, state_d;
    logic [4:0]        select_q, select_d;
    logic [24:0]       grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [3:0]        hold_q, hold_d;
    logic [4:0]        last_q, last_d;
    logic [CONF_W-1:0] cnt_q, cnt_d;

    logic        rr_found;
    logic [4:0]  rr_idx;
    logic [5:0]  scan_p;
    logic        contend;
    logic        own_const;
    logic        owner_req;
    logic        other_pend;
    logic        release_own;

    // Scan starts one past the last source owner and wraps 24 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_p   = '0;
        for (int k = 1; k <= 25; k++) begin
            scan_p = {1'b0, last_q} + 6'(k);
            if (scan_p >= 6'd25) scan_p = scan_p - 6'd25;
            if (!rr_found && bus.req[scan_p[4:0]]) begin
                rr_found = 1'b1;
                rr_idx   = scan_p[4:0];
            end
        end
    end

    assign contend = ((bus.req & (bus.req - 25'd1)) != '0) ||
                     (bus.const_req && (bus.req != '0));

    assign own_const  = (select_q == CONST_SEL);
    assign owner_req  = own_const ? bus.const_req : |(bus.req & grant_q);
    assign other_pend = own_const ? (bus.req != '0)
                                  : (((bus.req & ~grant_q) != '0) ||
                                     bus.const_req);
    assign release_own = !owner_req ||
                         ((hold_q == HOLD_LAST) && other_pend);

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        hold_d   = hold_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (bus.const_req) begin
                    state_d  = OWN;
                    select_d = CONST_SEL;
                    grant_d  = '0;
                    busy_d   = 1'b1;
                end else if (rr_found) begin
                    state_d  = OWN;
                    select_d = rr_idx + 5'd1;
                    grant_d  = 25'd1 << rr_idx;
                    busy_d   = 1'b1;
                    last_d   = rr_idx;
                end
            end
            OWN: begin
                if (release_own) begin
                    state_d  = IDLE;
                    select_d = '0;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    hold_d   = '0;
                end else if (hold_q != 4'd15) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear beats a same-cycle increment; count only while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.conflict_clr) begin
            cnt_d = '0;
        end else if (state_q == IDLE && contend && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            select_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            hold_q   <= '0;
            last_q   <= 5'd24;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.select       = select_q;
    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed bench for bus_grant_arbiter: vector table plus corner sequences.
// Expected values are hand-derived with MAX_HOLD=4, CONF_W=8.
module tb_bus_grant_arbiter;

    logic clk;
    logic clear_n;

    int checks;
    int errors;

    bus_grant_arbiter_if #(.CONF_W(8)) bus ();

    bus_grant_arbiter #(
        .MAX_HOLD (4),
        .CONF_W   (8)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic [24:0] req;
        logic        cr;
        logic        clr;
        logic [4:0]  sel;
        logic [24:0] gnt;
        logic        bsy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    localparam logic [24:0] RR = 25'h1000021;

    function automatic void add(input logic rn, input logic [24:0] r,
                                input logic cr, input logic cl,
                                input logic [4:0] s, input logic [24:0] g,
                                input logic b, input logic [7:0] c);
        vec_t v;
        v.rn = rn; v.req = r; v.cr = cr; v.clr = cl;
        v.sel = s; v.gnt = g; v.bsy = b; v.cnt = c;
        tbl.push_back(v);
    endfunction

    task automatic step(input logic rn, input logic [24:0] r,
                        input logic cr, input logic cl);
        clear_n          = rn;
        bus.req          = r;
        bus.const_req    = cr;
        bus.conflict_clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] s,
                           input logic [24:0] g, input logic b,
                           input logic [7:0] c);
        checks++;
        if (bus.select !== s || bus.grant !== g ||
            bus.busy !== b || bus.conflict_cnt !== c) begin
            errors++;
            $display("FAIL %s: got sel=%0d gnt=%h busy=%b cnt=%0d expected sel=%0d gnt=%h busy=%b cnt=%0d",
                     name, bus.select, bus.grant, bus.busy,
                     bus.conflict_cnt, s, g, b, c);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_n = 1'b0;
        bus.req = '0;
        bus.const_req = 1'b0;
        bus.conflict_clr = 1'b0;

        // reset with everything requesting, then a lone request
        add(0, '1, 1, 0, 0, 0, 0, 0);
        add(0, '1, 1, 0, 0, 0, 0, 0);
        add(1, 25'h8, 0, 0, 4, 25'h8, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // round-robin with timeout across sources 0, 5, 24
        for (int i = 0; i < 4; i++) add(1, RR, 0, 0, 1, 25'h1, 1, 1);
        add(1, RR, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(1, RR, 0, 0, 6, 25'h20, 1, 2);
        add(1, RR, 0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) add(1, RR, 0, 0, 25, 25'h1000000, 1, 3);
        add(1, RR, 0, 0, 0, 0, 0, 3);
        add(1, RR, 0, 0, 1, 25'h1, 1, 4);
        add(1, 0, 0, 0, 0, 0, 0, 4);
        // constant priority and turnaround
        add(1, 25'h80, 1, 0, 31, 0, 1, 5);
        add(1, 25'h80, 0, 0, 0, 0, 0, 5);
        add(1, 25'h80, 0, 0, 8, 25'h80, 1, 5);
        add(1, 0, 0, 0, 0, 0, 0, 5);
        // clear beats increment; scan wraps from 8 to source 1
        add(1, 25'h6, 0, 1, 2, 25'h2, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].req, tbl[i].cr, tbl[i].clr);
            chk_all($sformatf("vec[%0d]", i), tbl[i].sel, tbl[i].gnt,
                    tbl[i].bsy, tbl[i].cnt);
        end

        // unopposed owner never times out
        for (int i = 0; i < 20; i++) begin
            step(1, 25'h400, 0, 0);
            chk_all($sformatf("hold[%0d]", i), 11, 25'h400, 1, 0);
        end
        step(1, 0, 0, 0);
        chk_all("hold_rel", 0, 0, 0, 0);

        // contention counter saturation
        for (int i = 0; i < 300; i++) begin
            step(1, 25'h1800, 0, 0);
            chk($sformatf("sat[%0d]", i), 32'(bus.conflict_cnt),
                (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            step(1, 0, 0, 0);
        end
        step(1, 25'h1800, 0, 1);
        chk("sat_clr", 32'(bus.conflict_cnt), 32'd0);
        step(1, 0, 0, 0);
        chk_all("sat_idle", 0, 0, 0, 0);

        // reset while the constant owns the bus
        step(1, 0, 1, 0);
        chk_all("const_own", 31, 0, 1, 0);
        step(0, 25'h2001, 1, 0);
        chk_all("mid_rst", 0, 0, 0, 0);
        step(1, 25'h2001, 0, 0);
        chk_all("rr_restart", 1, 25'h1, 1, 1);
        step(1, 0, 0, 0);
        chk_all("final_idle", 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
